// File: rtl/read_ptr_empty_logic.sv
// Read-side FIFO pointer/empty logic: 2-flop write-pointer sync, Gray read pointer, registered empty/underflow.
// Optional registered almost_empty output when READ_ALMOST_EMPTY_EN is defined.
module read_ptr_empty_logic #(
  parameter int address = 2
`ifdef READ_ALMOST_EMPTY_EN
  ,
  parameter int almost_level = 1
`endif
) (
  input  logic               rclk,
  input  logic               rreset,
  input  logic               ren,
  input  logic [address:0]   write_ptr_gray,
  output logic [address:0]   read_ptr,
  output logic [address:0]   read_ptr_gray,
  output logic [address-1:0] read_addr,
  output logic               empty,
  output logic               underflow,
`ifdef READ_ALMOST_EMPTY_EN
  output logic               almost_empty,
`endif
  output logic [address:0]   rd_count
);

  logic [address:0] wq1_q, wq2_q;
  logic [address:0] wbin;
  logic [address:0] rbin_q, rbin_d;
  logic [address:0] rgray_q, rgray_d;
  logic             empty_q, empty_d;
  logic             underflow_q, underflow_d;
  logic             rinc;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  for (genvar i = 0; i <= address; i++) begin : g_g2b
    assign wbin[i] = ^wq2_q[address:i];
  end

  assign rinc        = ren & ~empty_q;
  assign rbin_d      = rbin_q + {{address{1'b0}}, rinc};
  assign rgray_d     = rbin_d ^ (rbin_d >> 1);
  assign empty_d     = (rgray_d == wq2_q);
  assign underflow_d = ren & empty_q;

  always_ff @(posedge rclk) begin
    if (rreset) begin
      wq1_q       <= '0;
      wq2_q       <= '0;
      rbin_q      <= '0;
      rgray_q     <= '0;
      empty_q     <= 1'b1;
      underflow_q <= 1'b0;
    end else begin
      wq1_q       <= write_ptr_gray;
      wq2_q       <= wq1_q;
      rbin_q      <= rbin_d;
      rgray_q     <= rgray_d;
      empty_q     <= empty_d;
      underflow_q <= underflow_d;
    end
  end

`ifdef READ_ALMOST_EMPTY_EN
  logic [address:0] occ_d;
  logic             almost_q;

  // Occupancy after this edge's read, against the already-synchronized write pointer.
  assign occ_d = wbin - rbin_d;

  always_ff @(posedge rclk) begin
    if (rreset) begin
      almost_q <= 1'b1;
    end else begin
      almost_q <= (occ_d <= (address+1)'(almost_level));
    end
  end

  assign almost_empty = almost_q;
`endif

  assign read_ptr      = rbin_q;
  assign read_ptr_gray = rgray_q;
  assign read_addr     = rbin_q[address-1:0];
  assign empty         = empty_q;
  assign underflow     = underflow_q;
  assign rd_count      = wbin - rbin_q;

endmodule

// File: tb/tb_read_ptr_empty_logic.sv
// Directed bench for read_ptr_empty_logic (address=2); define READ_ALMOST_EMPTY_EN to cover almost_empty.
module tb_read_ptr_empty_logic;

  logic       rclk;
  logic       rreset;
  logic       ren;
  logic [2:0] write_ptr_gray;
  logic [2:0] read_ptr;
  logic [2:0] read_ptr_gray;
  logic [1:0] read_addr;
  logic       empty;
  logic       underflow;
  logic [2:0] rd_count;
`ifdef READ_ALMOST_EMPTY_EN
  logic       almost_empty;
`endif

  int checks = 0;
  int errors = 0;

  read_ptr_empty_logic #(.address(2)) dut (
    .rclk           (rclk),
    .rreset         (rreset),
    .ren            (ren),
    .write_ptr_gray (write_ptr_gray),
    .read_ptr       (read_ptr),
    .read_ptr_gray  (read_ptr_gray),
    .read_addr      (read_addr),
    .empty          (empty),
    .underflow      (underflow),
`ifdef READ_ALMOST_EMPTY_EN
    .almost_empty   (almost_empty),
`endif
    .rd_count       (rd_count)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
  endtask

  initial begin
    rreset = 1'b1;
    ren = 1'b1;
    write_ptr_gray = 3'b000;

    // Reset with ren held high
    tick();
    chk("rst_read_ptr", read_ptr, 0);
    chk("rst_read_gray", read_ptr_gray, 0);
    chk("rst_read_addr", read_addr, 0);
    chk("rst_empty", empty, 1);
    chk("rst_underflow", underflow, 0);
`ifdef READ_ALMOST_EMPTY_EN
    chk("rst_almost", almost_empty, 1);
`endif

    // Latency: write pointer 0->1 just after edge 0
    rreset = 1'b0;
    ren = 1'b0;
    write_ptr_gray = 3'b001;
    tick();
    chk("lat_empty_e1", empty, 1);
    tick();
    chk("lat_empty_e2", empty, 1);
    tick();
    chk("lat_empty_e3", empty, 0);
    chk("lat_count_e3", rd_count, 1);

    ren = 1'b1;
    tick();
    chk("rd1_read_ptr", read_ptr, 1);
    chk("rd1_read_gray", read_ptr_gray, 3'b001);
    chk("rd1_empty", empty, 1);
    chk("rd1_count", rd_count, 0);

    // Underflow: read while empty
    tick();
    chk("uf_pulse", underflow, 1);
    chk("uf_read_ptr", read_ptr, 1);
    ren = 1'b0;
    tick();
    chk("uf_clear", underflow, 0);
    chk("uf_read_ptr_hold", read_ptr, 1);

    // Full occupancy: read_ptr=0, write pointer 4 (gray 110)
    rreset = 1'b1;
    tick();
    rreset = 1'b0;
    write_ptr_gray = 3'b110;
    tick();
    tick();
    chk("full_count", rd_count, 4);
    tick();
    chk("full_empty", empty, 0);
    ren = 1'b1;
    tick();
    tick();
    tick();
    chk("full_rd3_ptr", read_ptr, 3);
    chk("full_rd3_empty", empty, 0);
    tick();
    ren = 1'b0;
    chk("full_rd4_ptr", read_ptr, 4);
    chk("full_rd4_gray", read_ptr_gray, 3'b110);
    chk("full_rd4_addr", read_addr, 0);
    chk("full_rd4_empty", empty, 1);

    // Writes continue to pointer 8 (mod 8 = 0), reads wrap past 7
    write_ptr_gray = 3'b111;
    tick();
    write_ptr_gray = 3'b101;
    tick();
    write_ptr_gray = 3'b100;
    tick();
    write_ptr_gray = 3'b000;
    tick();
    tick();
    tick();
    chk("wrap_empty", empty, 0);
    chk("wrap_count", rd_count, 4);
    ren = 1'b1;
    tick();
    tick();
    tick();
    chk("wrap_ptr7", read_ptr, 7);
    chk("wrap_gray7", read_ptr_gray, 3'b100);
    tick();
    ren = 1'b0;
    chk("wrap_ptr0", read_ptr, 0);
    chk("wrap_gray0", read_ptr_gray, 3'b000);
    chk("wrap_addr0", read_addr, 0);
    chk("wrap_empty_end", empty, 1);

    // Mid-operation reset with rd_count=2 and a new write pointer in wq1
    write_ptr_gray = 3'b011;
    tick();
    tick();
    write_ptr_gray = 3'b010;
    tick();
    chk("mid_count_pre", rd_count, 2);
    chk("mid_empty_pre", empty, 0);
    rreset = 1'b1;
    tick();
    rreset = 1'b0;
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_ptr", read_ptr, 0);
    chk("mid_rst_count", rd_count, 0);
    tick();
    chk("mid_e1_empty", empty, 1);
    tick();
    chk("mid_e2_count", rd_count, 3);
    tick();
    chk("mid_e3_empty", empty, 0);

`ifdef READ_ALMOST_EMPTY_EN
    // Occupancy 3 -> 2 -> 1 by reads, then a write back to 2
    chk("ae_occ3", almost_empty, 0);
    ren = 1'b1;
    tick();
    chk("ae_occ2", almost_empty, 0);
    tick();
    ren = 1'b0;
    chk("ae_count1", rd_count, 1);
    chk("ae_occ1", almost_empty, 1);
    write_ptr_gray = 3'b110;
    tick();
    tick();
    chk("ae_sync_hold", almost_empty, 1);
    tick();
    chk("ae_occ2_write", almost_empty, 0);
    chk("ae_empty_write", empty, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
